// File: rtl/mod_exp.sv
// rtl/mod_exp.sv - modular exponentiation engine, RESULT = M^E mod N
//
// Right-to-left square-and-multiply around one bit-serial interleaved
// (Blakley) modular multiplier that consumes one bit of A per cycle, MSB first.
//
// Ports:
//   CLK     in   system clock, all state changes on the rising edge
//   RESET   in   synchronous active-high reset, abandons any job
//   GO      in   start request, level-sampled in IDLE only
//   M       in   BITS  base, any value (reduced by the PRE multiply)
//   E       in   BITS  exponent
//   N       in   BITS  modulus
//   RESULT  out  BITS  M^E mod N, valid while DONE=1, held otherwise
//   DONE    out  high in DONE state
//   BUSY    out  high while a multiply sequence is running
module mod_exp #(
  parameter int BITS = 128
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            GO,
  input  logic [BITS-1:0] M,
  input  logic [BITS-1:0] E,
  input  logic [BITS-1:0] N,
  output logic [BITS-1:0] RESULT,
  output logic            DONE,
  output logic            BUSY
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_MUL_R = 3'd2;
  localparam logic [2:0] S_MUL_B = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state;
  logic [BITS-1:0] ereg, nreg, areg, r, bm;
  logic [BITS+1:0] p;
  logic [CW-1:0]   cnt;

  logic [BITS-1:0] a_op, b_op, prod, e_next;
  logic            a_bit, last;
  logic [BITS+1:0] p2, p_next, n_ext, n2;

  // One multiply step. P < N holds on entry, so 2P + Bop < 3N and at most
  // one of the two subtractions is needed to bring the sum back below N.
  always_comb begin
    a_op = bm;
    b_op = bm;
    case (state)
      S_PRE:   begin a_op = areg; b_op = BITS'(1); end
      S_MUL_R: a_op = r;
      default: ;
    endcase
    a_bit = a_op[cnt];
    n_ext = {2'b00, nreg};
    n2    = n_ext << 1;
    p2    = (p << 1) + (a_bit ? {2'b00, b_op} : '0);
    if (p2 >= n2)
      p_next = p2 - n2;
    else if (p2 >= n_ext)
      p_next = p2 - n_ext;
    else
      p_next = p2;
    prod   = p_next[BITS-1:0];
    last   = (cnt == '0);
    // A squaring consumes one exponent bit; the R multiply does not.
    e_next = (state == S_MUL_B) ? (ereg >> 1) : ereg;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      RESULT <= '0;
      ereg   <= '0;
      nreg   <= '0;
      areg   <= '0;
      r      <= '0;
      bm     <= '0;
      p      <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (GO) begin
            ereg  <= E;
            nreg  <= N;
            areg  <= M;
            r     <= BITS'(1);
            bm    <= BITS'(1);
            p     <= '0;
            cnt   <= CW'(BITS-1);
            state <= S_PRE;
          end
        end
        S_PRE, S_MUL_R, S_MUL_B: begin
          if (state == S_PRE && nreg[BITS-1:1] == '0) begin
            // Modulus 0 or 1: everything reduces to 0, skip the arithmetic.
            RESULT <= '0;
            state  <= S_DONE;
          end else if (!last) begin
            p   <= p_next;
            cnt <= cnt - CW'(1);
          end else begin
            p    <= '0;
            cnt  <= CW'(BITS-1);
            ereg <= e_next;
            if (state == S_MUL_R) begin
              r <= prod;
              if (e_next[BITS-1:1] != '0)
                state <= S_MUL_B;
              else begin
                RESULT <= prod;
                state  <= S_DONE;
              end
            end else begin
              bm <= prod;
              if (e_next[0])
                state <= S_MUL_R;
              else if (e_next[BITS-1:1] != '0)
                state <= S_MUL_B;
              else begin
                // No bits left to multiply in: R already holds the answer.
                RESULT <= r;
                state  <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (!GO)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign DONE = (state == S_DONE);
  assign BUSY = (state == S_PRE) || (state == S_MUL_R) || (state == S_MUL_B);

endmodule
